// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: PC, 2-entry prefetch FIFO, redirect and start/stop.
// Optional stall counter output enabled by FETCH_STALL_CNT_EN.
module imem_fetch_ctrl #(
  parameter int N   = 32,
  parameter int AW  = 6,
  parameter int PCW = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           stop,
  output logic [AW-1:0]  imem_addr,
  input  logic [N-1:0]   imem_q,
  input  logic           redirect_valid,
  input  logic [PCW-1:0] redirect_pc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_instr,
  output logic [PCW-1:0] out_pc,
  output logic           busy
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]    stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e         state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [N-1:0]   e0_instr_q, e0_instr_d;
  logic [N-1:0]   e1_instr_q, e1_instr_d;
  logic [PCW-1:0] e0_pc_q, e0_pc_d;
  logic [PCW-1:0] e1_pc_q, e1_pc_d;

  logic           pop;
  logic           push;
  logic [1:0]     cnt_pop;
  logic           unused_lo;

  assign unused_lo = ^redirect_pc[1:0];

  assign imem_addr = pc_q[AW+1:2];
  assign out_valid = (cnt_q != 2'd0);
  assign out_instr = e0_instr_q;
  assign out_pc    = e0_pc_q;
  assign busy      = (state_q != S_IDLE);

  // Entry 0 is always the head; pushes land in the first free slot after the pop.
  always_comb begin
    pc_d       = pc_q;
    e0_instr_d = e0_instr_q;
    e1_instr_d = e1_instr_q;
    e0_pc_d    = e0_pc_q;
    e1_pc_d    = e1_pc_q;

    pop     = out_valid && out_ready;
    push    = (state_q == S_RUN) && !redirect_valid
              && ((cnt_q != 2'd2) || pop);
    cnt_pop = cnt_q - {1'b0, pop};

    if (pop) begin
      e0_instr_d = e1_instr_q;
      e0_pc_d    = e1_pc_q;
    end

    if (push) begin
      if (cnt_pop == 2'd0) begin
        e0_instr_d = imem_q;
        e0_pc_d    = pc_q;
      end else begin
        e1_instr_d = imem_q;
        e1_pc_d    = pc_q;
      end
      pc_d = pc_q + PCW'(4);
    end

    cnt_d = cnt_pop + {1'b0, push};

    if (redirect_valid) begin
      cnt_d      = 2'd0;
      pc_d       = {redirect_pc[PCW-1:2], 2'b00};
      e0_instr_d = '0;
      e1_instr_d = '0;
      e0_pc_d    = '0;
      e1_pc_d    = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) state_d = S_RUN;
      end
      S_RUN: begin
        if (stop) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (redirect_valid)       state_d = S_IDLE;
        else if (start && !stop)  state_d = S_RUN;
        else if (cnt_d == 2'd0)   state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      cnt_q      <= '0;
      e0_instr_q <= '0;
      e1_instr_q <= '0;
      e0_pc_q    <= '0;
      e1_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      e0_instr_q <= e0_instr_d;
      e1_instr_q <= e1_instr_d;
      e0_pc_q    <= e0_pc_d;
      e1_pc_q    <= e1_pc_d;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start) begin
      stall_d = '0;
    end else if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed table-driven bench for imem_fetch_ctrl with a behavioural ROM.
// Word k of the ROM is 0xA0000000 + k.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic [5:0]  imem_addr;
  logic [31:0] imem_q;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        busy;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_vec;
  int n_err;

  imem_fetch_ctrl #(.N(32), .AW(6), .PCW(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .imem_addr      (imem_addr),
    .imem_q         (imem_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .busy           (busy)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  assign imem_q = 32'hA000_0000 + {26'd0, imem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        sp;
    logic        rdy;
    logic        rv;
    logic [63:0] rpc;
    logic        ev;
    logic        eb;
    logic [63:0] epc;
    logic [31:0] ei;
    logic [5:0]  ea;
  } vec_t;

  vec_t v[26];

  function automatic vec_t mk(logic st, logic sp, logic rdy, logic rv,
                              logic [63:0] rpc, logic ev, logic eb,
                              logic [63:0] epc, logic [31:0] ei,
                              logic [5:0] ea);
    vec_t r;
    r.st = st; r.sp = sp; r.rdy = rdy; r.rv = rv; r.rpc = rpc;
    r.ev = ev; r.eb = eb; r.epc = epc; r.ei = ei; r.ea = ea;
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic st, logic sp, logic rdy, logic rv,
                       logic [63:0] rpc);
    start          = st;
    stop           = sp;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 64'd0);

    // sequential fetch, backpressure
    v[0]  = mk(1, 0, 1, 0, 64'h0,  0, 1, 64'h0,   32'h0,         6'd0);
    v[1]  = mk(0, 0, 1, 0, 64'h0,  1, 1, 64'h0,   32'hA000_0000, 6'd1);
    v[2]  = mk(0, 0, 1, 0, 64'h0,  1, 1, 64'h4,   32'hA000_0001, 6'd2);
    v[3]  = mk(0, 0, 1, 0, 64'h0,  1, 1, 64'h8,   32'hA000_0002, 6'd3);
    v[4]  = mk(0, 0, 0, 0, 64'h0,  1, 1, 64'h8,   32'hA000_0002, 6'd4);
    v[5]  = mk(0, 0, 0, 0, 64'h0,  1, 1, 64'h8,   32'hA000_0002, 6'd4);
    v[6]  = mk(0, 0, 0, 0, 64'h0,  1, 1, 64'h8,   32'hA000_0002, 6'd4);
    v[7]  = mk(0, 0, 1, 0, 64'h0,  1, 1, 64'hC,   32'hA000_0003, 6'd5);
    v[8]  = mk(0, 0, 1, 0, 64'h0,  1, 1, 64'h10,  32'hA000_0004, 6'd6);
    // misaligned redirect with a full FIFO
    v[9]  = mk(0, 0, 1, 1, 64'h2E, 0, 1, 64'h0,   32'h0,         6'd11);
    v[10] = mk(0, 0, 1, 0, 64'h0,  1, 1, 64'h2C,  32'hA000_000B, 6'd12);
    v[11] = mk(0, 0, 0, 0, 64'h0,  1, 1, 64'h2C,  32'hA000_000B, 6'd13);
    // stop with two buffered
    v[12] = mk(0, 1, 1, 0, 64'h0,  1, 1, 64'h30,  32'hA000_000C, 6'd14);
    v[13] = mk(0, 0, 1, 0, 64'h0,  1, 1, 64'h34,  32'hA000_000D, 6'd14);
    v[14] = mk(0, 0, 1, 0, 64'h0,  0, 0, 64'h0,   32'h0,         6'd14);
    // redirect in IDLE, wrap past the ROM end
    v[15] = mk(0, 0, 1, 1, 64'hFC, 0, 0, 64'h0,   32'h0,         6'd63);
    v[16] = mk(1, 0, 0, 0, 64'h0,  0, 1, 64'h0,   32'h0,         6'd63);
    v[17] = mk(0, 0, 0, 0, 64'h0,  1, 1, 64'hFC,  32'hA000_003F, 6'd0);
    v[18] = mk(0, 0, 1, 0, 64'h0,  1, 1, 64'h100, 32'hA000_0000, 6'd1);
    v[19] = mk(0, 0, 0, 0, 64'h0,  1, 1, 64'h100, 32'hA000_0000, 6'd2);
    // start+stop in RUN, redirect in DRAIN, start+stop in IDLE
    v[20] = mk(1, 1, 0, 0, 64'h0,  1, 1, 64'h100, 32'hA000_0000, 6'd2);
    v[21] = mk(0, 0, 0, 1, 64'h40, 0, 0, 64'h0,   32'h0,         6'd16);
    v[22] = mk(1, 1, 1, 0, 64'h0,  0, 0, 64'h0,   32'h0,         6'd16);
    v[23] = mk(0, 0, 1, 0, 64'h0,  0, 0, 64'h0,   32'h0,         6'd16);
    v[24] = mk(1, 0, 1, 0, 64'h0,  0, 1, 64'h0,   32'h0,         6'd16);
    v[25] = mk(0, 0, 1, 0, 64'h0,  1, 1, 64'h40,  32'hA000_0010, 6'd17);

    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy",  {63'd0, busy},      64'd0);
    check("rst_pc",    out_pc,             64'd0);
    check("rst_instr", {32'd0, out_instr}, 64'd0);
    check("rst_addr",  {58'd0, imem_addr}, 64'd0);
`ifdef FETCH_STALL_CNT_EN
    check("rst_stall", {32'd0, stall_cnt}, 64'd0);
`endif

    for (int i = 0; i < 26; i++) begin
      drive(v[i].st, v[i].sp, v[i].rdy, v[i].rv, v[i].rpc);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), {63'd0, out_valid}, {63'd0, v[i].ev});
      check($sformatf("v%0d_busy", i),  {63'd0, busy},      {63'd0, v[i].eb});
      check($sformatf("v%0d_addr", i),  {58'd0, imem_addr}, {58'd0, v[i].ea});
      if (v[i].ev) begin
        check($sformatf("v%0d_pc", i),    out_pc,             v[i].epc);
        check($sformatf("v%0d_instr", i), {32'd0, out_instr}, {32'd0, v[i].ei});
      end
    end

    // fill FIFO under backpressure, then async reset mid-cycle
    drive(1, 0, 0, 0, 64'd0);
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("full_valid", {63'd0, out_valid}, 64'd1);
    check("full_pc",    out_pc,             64'h40);
    check("full_addr",  {58'd0, imem_addr}, 64'd18);
`ifdef FETCH_STALL_CNT_EN
    check("stall_cnt",  {32'd0, stall_cnt}, 64'd2);
`endif
    #3 reset = 1'b1;
    #1;
    check("arst_valid", {63'd0, out_valid}, 64'd0);
    check("arst_busy",  {63'd0, busy},      64'd0);
    check("arst_pc",    out_pc,             64'd0);
    check("arst_addr",  {58'd0, imem_addr}, 64'd0);
`ifdef FETCH_STALL_CNT_EN
    check("arst_stall", {32'd0, stall_cnt}, 64'd0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    drive(0, 0, 1, 0, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("post_valid", {63'd0, out_valid}, 64'd0);
    check("post_busy",  {63'd0, busy},      64'd0);
    check("post_addr",  {58'd0, imem_addr}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
